mem_arb: RTL and testbench

- Single-port memory arbiter directly downstream of the instruction-cache and data-cache controllers.
- Merges icache read requests and dcache read/write requests (block fill, write-back, flush, count-store) onto the one RAM port.
- Returns per-requester wait/data signals to each cache.
- Holds a grant for as long as the owner keeps its request asserted, so multi-word dcache bursts (WB→READ, FLUSH pairs) are never interleaved with icache fetches.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_timeout.sv | 49 ++++
 rtl/mem_arb.sv | 119 +++++++++++
 tb/tb_mem_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and default widths for the icache/dcache memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Behavioural RAM responder modes, used by benches driving ram_ready
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module : arb_timeout
// Brief  : Saturating stall counter for a RAM grant plus sticky error flag.
// Rev    : 1.0  initial release
// ============================================================================
module arb_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant,
    input  logic i_en,
    input  logic i_ready,
    input  logic i_state_chg,
    output logic o_err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_grant || i_ready || i_state_chg) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != c_limit)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // The flag latches on the edge the counter lands on the limit
        err_d = err_q | (cnt_d == c_limit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_arb
// Brief  : Single-port RAM arbiter between icache reads and dcache reads/writes.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              err
);

    arb_state_t state_d, state_q;
    logic       last_d_d, last_d_q;
    logic       w_dreq;

    assign w_dreq = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                // Round-robin only matters on a tie; last_d favours the other side
                if (w_dreq && (!iREN || !last_d_q)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (!w_dreq) begin
                    last_d_d = 1'b1;
                    state_d  = iREN ? IGRANT : IDLE;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    last_d_d = 1'b0;
                    state_d  = w_dreq ? DGRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~(ram_ready & w_dreq);
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~(ram_ready & iREN);
            end
            default: ;
        endcase
    end

    arb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk        (CLK),
        .rst        (RST),
        .i_grant    (state_q != IDLE),
        .i_en       (ramREN | ramWEN),
        .i_ready    (ram_ready),
        .i_state_chg(state_d != state_q),
        .o_err      (err)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arb
// Brief  : Self-checking bench for mem_arb: directed scenarios plus random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_I    = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] dstore = '0, ramload = '0;
    logic          iwait, dwait, ramREN, ramWEN, err;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;

    ramstate_t ram_mode = FREE;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, who went last, how long it has stalled
    int m_owner  = OWN_NONE;
    bit m_last_d = 1'b0;
    int m_stall  = 0;
    bit m_err    = 1'b0;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; inputs are stable from posedge+1 to the next posedge
    always @(negedge CLK) begin
        logic          e_iw, e_dw, e_ren, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        int            nxt;
        bit            dreq;
        e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        dreq = dREN | dWEN;
        if (!RST && m_owner == OWN_D) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN & ~dWEN;
            e_dw = ~(ram_ready & dreq);
        end else if (!RST && m_owner == OWN_I) begin
            e_addr = iaddr; e_ren = iREN;
            e_iw = ~(ram_ready & iREN);
        end
        check("iwait",    64'(iwait),    64'(e_iw));
        check("dwait",    64'(dwait),    64'(e_dw));
        check("ramREN",   64'(ramREN),   64'(e_ren));
        check("ramWEN",   64'(ramWEN),   64'(e_wen));
        check("ramaddr",  64'(ramaddr),  64'(e_addr));
        check("ramstore", 64'(ramstore), 64'(e_store));
        check("err",      64'(err),      64'(RST ? 1'b0 : m_err));
        check("iload",    64'(iload),    64'(ramload));
        check("dload",    64'(dload),    64'(ramload));
        if (RST) begin
            m_owner = OWN_NONE; m_last_d = 1'b0; m_stall = 0; m_err = 1'b0;
        end else begin
            nxt = m_owner;
            if (m_owner == OWN_NONE) begin
                if (dreq && iREN) nxt = m_last_d ? OWN_I : OWN_D;
                else if (dreq)    nxt = OWN_D;
                else if (iREN)    nxt = OWN_I;
            end else if (m_owner == OWN_D && !dreq) begin
                m_last_d = 1'b1;
                nxt = iREN ? OWN_I : OWN_NONE;
            end else if (m_owner == OWN_I && !iREN) begin
                m_last_d = 1'b0;
                nxt = dreq ? OWN_D : OWN_NONE;
            end
            if (m_owner != OWN_NONE && nxt == m_owner && (e_ren || e_wen) && !ram_ready)
                m_stall = (m_stall < TO) ? m_stall + 1 : TO;
            else
                m_stall = 0;
            if (m_stall == TO) m_err = 1'b1;
            m_owner = nxt;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    endtask

    initial begin
        int pulses;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_iwait",  64'(iwait),   64'(1));
        check("reset_dwait",  64'(dwait),   64'(1));
        check("reset_ramREN", 64'(ramREN),  64'(0));
        check("reset_ramaddr",64'(ramaddr), 64'(0));
        RST = 1'b0;

        // Lone dcache read, RAM answers on the second granted cycle
        step(); dREN = 1'b1; daddr = 32'h40; ramload = 32'hDEADBEEF; #1;
        check("t1_idle_ren", 64'(ramREN), 64'(0));
        step(); #1;
        check("t1_ren",  64'(ramREN),  64'(1));
        check("t1_addr", 64'(ramaddr), 64'(32'h40));
        check("t1_wait", 64'(dwait),   64'(1));
        step(); ram_ready = 1'b1; #1;
        check("t1_done",  64'(dwait), 64'(0));
        check("t1_dload", 64'(dload), 64'(32'hDEADBEEF));
        check("t1_iwait", 64'(iwait), 64'(1));
        step(); dREN = 1'b0; ram_ready = 1'b0; #1;
        check("t1_single_pulse", 64'(dwait), 64'(1));

        // Simultaneous first requests after reset: dcache first, then icache without bubble
        step(); RST = 1'b1; step(); RST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
        ram_ready = 1'b1; ramload = 32'hA5A50001; #1;
        check("t2_idle", 64'(ramREN), 64'(0));
        step(); #1;
        check("t2_daddr", 64'(ramaddr), 64'(32'h200));
        check("t2_dwait", 64'(dwait),   64'(0));
        check("t2_iwait", 64'(iwait),   64'(1));
        step(); dREN = 1'b0; #1;
        check("t2_dexit", 64'(ramREN), 64'(0));
        step(); #1;
        check("t2_iaddr", 64'(ramaddr), 64'(32'h100));
        check("t2_iwait_low", 64'(iwait), 64'(0));
        check("t2_iload", 64'(iload), 64'(32'hA5A50001));
        step(); drop_all();

        // Burst lock: two writes then two reads with icache waiting throughout
        step(); dWEN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h400;
        dstore = 32'hCAFE0000; ram_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 2) begin dWEN = 1'b0; dREN = 1'b1; end
            daddr = 32'h300 + 32'(k * 4);
            #1;
            if (dwait == 1'b0) pulses++;
            check("t3_no_icache", 64'(ramaddr == iaddr), 64'(0));
        end
        check("t3_pulses", 64'(pulses), 64'(4));
        step(); dREN = 1'b0; #1;
        check("t3_exit_dwait", 64'(dwait), 64'(1));
        step(); #1;
        check("t3_igrant", 64'(ramaddr), 64'(32'h400));
        step(); drop_all();

        // Round-robin after a dcache grant, then after an icache grant; write beats read
        step(); dWEN = 1'b1; daddr = 32'h500; ram_ready = 1'b1;
        step();
        step(); dWEN = 1'b0;
        step(); iREN = 1'b1; dWEN = 1'b1; iaddr = 32'h600; daddr = 32'h700;
        step(); #1;
        check("t4_i_wins", 64'(ramaddr), 64'(32'h600));
        check("t4_i_nowen", 64'(ramWEN), 64'(0));
        step(); iREN = 1'b0; dWEN = 1'b0;
        step(); iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h800; dstore = 32'h12345678;
        step(); #1;
        check("t4_d_wins", 64'(ramaddr),  64'(32'h800));
        check("t5_wen",    64'(ramWEN),   64'(1));
        check("t5_ren",    64'(ramREN),   64'(0));
        check("t5_store",  64'(ramstore), 64'(32'h12345678));
        step(); drop_all();

        // Timeout: RAM never ready while dcache writes
        step(); dWEN = 1'b1; daddr = 32'h900;
        for (int s = 1; s <= TO; s++) begin
            step(); #1;
            check("t6_err_low", 64'(err), 64'(0));
        end
        step(); #1;
        check("t6_err_set", 64'(err), 64'(1));
        repeat (3) step();
        #1;
        check("t6_err_sticky", 64'(err), 64'(1));
        step(); RST = 1'b1; #1;
        check("t6_rst_err", 64'(err),     64'(0));
        check("t6_rst_wen", 64'(ramWEN),  64'(0));
        check("t6_rst_addr",64'(ramaddr), 64'(0));
        step(); RST = 1'b0; drop_all();

        // Random traffic with sticky requests so bursts and handoffs occur
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 100 == 0) begin
                case ($urandom_range(0, 5))
                    0:       ram_mode = FREE;
                    1:       ram_mode = BUSY;
                    default: ram_mode = ACCESS;
                endcase
            end
            if ($urandom_range(0, 9) < 3) iREN = ~iREN;
            if ($urandom_range(0, 9) < 3) dREN = ~dREN;
            if ($urandom_range(0, 9) < 2) dWEN = ~dWEN;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            case (ram_mode)
                FREE:    ram_ready = 1'b1;
                BUSY:    ram_ready = 1'b0;
                default: ram_ready = ($urandom_range(0, 9) < 7);
            endcase
            RST = ($urandom_range(0, 399) == 0);
        end
        step(); RST = 1'b0; drop_all();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
